// File: rtl/ps2_receiver_pkg.sv
// Shared types and constants for the PS/2 keyboard receive path.
// Scancode_t is also consumed by the scancode translator.
package ps2_receiver_pkg;

    typedef logic [7:0] Scancode_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } Ps2RxState_t;

    localparam int   PS2_FRAME_BITS = 11;
    localparam logic PS2_IDLE_LEVEL = 1'b1;

    // PS/2 uses odd parity over the eight data bits plus the parity bit
    function automatic logic odd_parity_ok(input Scancode_t data, input logic parity);
        return (^{data, parity}) == 1'b1;
    endfunction

endpackage

// File: rtl/ps2_input_filter.sv
// Synchroniser plus glitch filter for the raw PS/2 clock pin.
// fall_edge is a registered one-cycle strobe on each filtered 1->0 transition.
module ps2_input_filter
    import ps2_receiver_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int FILTER_LEN  = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic fall_edge
);

    localparam int CW = $clog2(FILTER_LEN + 1);

    logic [SYNC_STAGES-1:0] sync_r;
    logic [CW-1:0]          cnt_r;
    logic [CW-1:0]          cnt_s;
    logic                   filt_r;
    logic                   filt_s;
    logic                   fall_r;
    logic                   fall_s;
    logic                   sync_bit_s;

    assign sync_bit_s = sync_r[SYNC_STAGES-1];
    assign fall_edge  = fall_r;

    // Metastability synchroniser chain
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_r <= {SYNC_STAGES{PS2_IDLE_LEVEL}};
        end else begin
            sync_r <= {sync_r[SYNC_STAGES-2:0], raw};
        end
    end

    // Count consecutive samples that disagree with the filtered level
    always_comb begin
        cnt_s  = '0;
        filt_s = filt_r;
        fall_s = 1'b0;
        if (sync_bit_s != filt_r) begin
            if (cnt_r == CW'(FILTER_LEN - 1)) begin
                filt_s = sync_bit_s;
                fall_s = filt_r;
                cnt_s  = '0;
            end else begin
                cnt_s  = cnt_r + CW'(1);
            end
        end else begin
            cnt_s = '0;
        end
    end

    // Filter state registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r  <= '0;
            filt_r <= PS2_IDLE_LEVEL;
            fall_r <= 1'b0;
        end else begin
            cnt_r  <= cnt_s;
            filt_r <= filt_s;
            fall_r <= fall_s;
        end
    end

endmodule

// File: rtl/ps2_receiver.sv
// PS/2 device-to-host frame receiver: deserialises one 11-bit frame into a
// scancode byte, rejecting bad parity, bad stop bit and stalled frames.
module ps2_receiver
    import ps2_receiver_pkg::*;
#(
    parameter int SYNC_STAGES    = 2,
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic      clk,
    input  logic      rst_n,
    input  logic      ps2Clk,
    input  logic      ps2Data,
    output Scancode_t scancode,
    output logic      scancodeDone,
    output logic      frameError
);

    localparam int             TW        = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0]  TMO_LAST  = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [TW-1:0]  TMO_MAX   = {TW{1'b1}};
    localparam int             DATA_BITS = PS2_FRAME_BITS - 3;

    logic [SYNC_STAGES-1:0] data_sync_r;
    logic                   data_bit_s;
    logic                   fall_edge_s;

    Ps2RxState_t state_r, state_s;
    logic [3:0]  bit_cnt_r, bit_cnt_s;
    Scancode_t   shift_r, shift_s;
    logic        parity_r, parity_s;
    logic [TW-1:0] tmo_cnt_r, tmo_cnt_s;
    Scancode_t   scancode_r, scancode_s;
    logic        done_r, done_s;
    logic        err_r, err_s;

    assign data_bit_s   = data_sync_r[SYNC_STAGES-1];
    assign scancode     = scancode_r;
    assign scancodeDone = done_r;
    assign frameError   = err_r;

    ps2_input_filter #(
        .SYNC_STAGES (SYNC_STAGES),
        .FILTER_LEN  (FILTER_LEN)
    ) u_clk_filter (
        .clk       (clk),
        .rst_n     (rst_n),
        .raw       (ps2Clk),
        .fall_edge (fall_edge_s)
    );

    // Data pin needs only synchronising; it is sampled while the clock is low
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_sync_r <= {SYNC_STAGES{PS2_IDLE_LEVEL}};
        end else begin
            data_sync_r <= {data_sync_r[SYNC_STAGES-2:0], ps2Data};
        end
    end

    // Next-state, frame checks and timeout supervision
    always_comb begin
        state_s    = state_r;
        bit_cnt_s  = bit_cnt_r;
        shift_s    = shift_r;
        parity_s   = parity_r;
        scancode_s = scancode_r;
        done_s     = 1'b0;
        err_s      = 1'b0;

        if (fall_edge_s || (state_r == IDLE)) begin
            tmo_cnt_s = '0;
        end else if (tmo_cnt_r != TMO_MAX) begin
            tmo_cnt_s = tmo_cnt_r + TW'(1);
        end else begin
            tmo_cnt_s = tmo_cnt_r;
        end

        if (fall_edge_s) begin
            case (state_r)
                IDLE: begin
                    if (data_bit_s == 1'b0) begin
                        state_s   = DATA;
                        bit_cnt_s = 4'd0;
                    end else begin
                        state_s   = IDLE;
                    end
                end
                DATA: begin
                    shift_s   = {data_bit_s, shift_r[7:1]};
                    bit_cnt_s = bit_cnt_r + 4'd1;
                    if (bit_cnt_r == 4'(DATA_BITS - 1)) begin
                        state_s = PARITY;
                    end else begin
                        state_s = DATA;
                    end
                end
                PARITY: begin
                    parity_s = data_bit_s;
                    state_s  = STOP;
                end
                STOP: begin
                    if (odd_parity_ok(shift_r, parity_r) && (data_bit_s == 1'b1)) begin
                        scancode_s = shift_r;
                        done_s     = 1'b1;
                    end else begin
                        err_s      = 1'b1;
                    end
                    state_s = IDLE;
                end
                default: begin
                    state_s = IDLE;
                end
            endcase
        end else if ((state_r != IDLE) && (tmo_cnt_r == TMO_LAST)) begin
            // Stalled frame: drop the partial byte
            state_s   = IDLE;
            err_s     = 1'b1;
            bit_cnt_s = 4'd0;
            shift_s   = '0;
        end else begin
            state_s = state_r;
        end
    end

    // Receiver state and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= IDLE;
            bit_cnt_r  <= 4'd0;
            shift_r    <= '0;
            parity_r   <= 1'b0;
            tmo_cnt_r  <= '0;
            scancode_r <= 8'h00;
            done_r     <= 1'b0;
            err_r      <= 1'b0;
        end else begin
            state_r    <= state_s;
            bit_cnt_r  <= bit_cnt_s;
            shift_r    <= shift_s;
            parity_r   <= parity_s;
            tmo_cnt_r  <= tmo_cnt_s;
            scancode_r <= scancode_s;
            done_r     <= done_s;
            err_r      <= err_s;
        end
    end

endmodule

// File: tb/tb_ps2_receiver.sv
// Bench for ps2_receiver: drives PS/2 frames and compares every output pulse
// with an ordered queue of outcomes predicted from the frame contents.
module tb_ps2_receiver;

    localparam int SYNC_STAGES    = 2;
    localparam int FILTER_LEN     = 8;
    localparam int TIMEOUT_CYCLES = 400;
    localparam int HALF           = 20;

    logic       clk     = 1'b0;
    logic       rst_n   = 1'b0;
    logic       ps2Clk  = 1'b1;
    logic       ps2Data = 1'b1;
    logic [7:0] scancode;
    logic       scancodeDone;
    logic       frameError;

    typedef struct packed {
        logic       err;
        logic [7:0] data;
    } exp_t;

    exp_t       exp_q[$];
    exp_t       mon_e;
    int         n_tests   = 0;
    int         n_fail    = 0;
    logic [7:0] last_good = 8'h00;
    logic       prev_done = 1'b0;
    logic       prev_err  = 1'b0;
    bit         mon_en    = 1'b0;

    always #5 clk = ~clk;

    ps2_receiver #(
        .SYNC_STAGES    (SYNC_STAGES),
        .FILTER_LEN     (FILTER_LEN),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .ps2Clk       (ps2Clk),
        .ps2Data      (ps2Data),
        .scancode     (scancode),
        .scancodeDone (scancodeDone),
        .frameError   (frameError)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_tests++;
        if (obs !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, expv);
        end
    endtask

    // One PS/2 bit cell: data set while clock high, then clock low phase
    task automatic ps2_bit(input logic b, input bit glitch);
        @(posedge clk); #1 ps2Data = b;
        if (glitch) begin
            repeat (HALF / 2) @(posedge clk);
            #1 ps2Clk = 1'b0;
            repeat (3) @(posedge clk);
            #1 ps2Clk = 1'b1;
            repeat (HALF - HALF / 2 - 1) @(posedge clk);
        end else begin
            repeat (HALF) @(posedge clk);
        end
        #1 ps2Clk = 1'b0;
        repeat (HALF) @(posedge clk);
        #1 ps2Clk = 1'b1;
    endtask

    // Sends the first nbits of a frame; a complete frame queues its predicted outcome
    task automatic send_frame(input logic [7:0] d, input bit bad_par, input bit bad_stop,
                              input int nbits, input bit glitch);
        logic [10:0] fr;
        logic        par;
        exp_t        e;
        par = ~(^d) ^ bad_par;
        fr  = {~bad_stop, par, d, 1'b0};
        if (nbits == 11) begin
            e.err  = bad_par | bad_stop;
            e.data = d;
            exp_q.push_back(e);
        end
        for (int i = 0; i < nbits; i++) begin
            ps2_bit(fr[i], glitch && (i == 3));
        end
    endtask

    task automatic wait_drain(input int budget);
        int n;
        n = 0;
        while ((exp_q.size() != 0) && (n < budget)) begin
            @(posedge clk);
            n++;
        end
        check_eq("drain", exp_q.size(), 0);
    endtask

    task automatic clk_glitch();
        @(posedge clk); #1 ps2Clk = 1'b0;
        repeat (3) @(posedge clk);
        #1 ps2Clk = 1'b1;
        repeat (30) @(posedge clk);
    endtask

    // Pulse monitor against the expected-outcome queue
    always @(negedge clk) begin
        if (mon_en && rst_n) begin
            if (scancodeDone || frameError) begin
                check_eq("exclusive", scancodeDone & frameError, 0);
                check_eq("pulse_width", (scancodeDone & prev_done) | (frameError & prev_err), 0);
                check_eq("spurious", exp_q.size() > 0, 1);
                if (exp_q.size() > 0) begin
                    mon_e = exp_q.pop_front();
                    check_eq("kind", frameError, mon_e.err);
                    if (!mon_e.err) begin
                        check_eq("scancode", scancode, mon_e.data);
                        last_good = mon_e.data;
                    end else begin
                        check_eq("held", scancode, last_good);
                    end
                end
            end
            prev_done = scancodeDone;
            prev_err  = frameError;
        end else begin
            prev_done = 1'b0;
            prev_err  = 1'b0;
        end
    end

    initial begin
        exp_t te;
        logic [7:0] d;
        int         kind;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_scancode", scancode, 8'h00);
        check_eq("rst_done", scancodeDone, 0);
        check_eq("rst_err", frameError, 0);
        rst_n  = 1'b1;
        mon_en = 1'b1;
        repeat (10) @(posedge clk);

        send_frame(8'h1C, 0, 0, 11, 0);
        wait_drain(200);
        send_frame(8'hF0, 0, 0, 11, 0);
        send_frame(8'h1C, 0, 0, 11, 0);
        wait_drain(200);
        send_frame(8'h1C, 1, 0, 11, 0);
        wait_drain(200);
        send_frame(8'h1C, 0, 1, 11, 0);
        send_frame(8'h12, 0, 0, 11, 0);
        wait_drain(200);

        // Stall after start + 4 data bits
        te.err  = 1'b1;
        te.data = 8'h00;
        exp_q.push_back(te);
        send_frame(8'h5A, 0, 0, 5, 0);
        wait_drain(TIMEOUT_CYCLES + 200);
        send_frame(8'h59, 0, 0, 11, 0);
        wait_drain(200);

        clk_glitch();
        clk_glitch();
        send_frame(8'hA5, 0, 0, 11, 1);
        wait_drain(200);

        // Reset in the middle of a frame
        send_frame(8'h3C, 0, 0, 6, 0);
        repeat (5) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check_eq("midrst_scancode", scancode, 8'h00);
        check_eq("midrst_done", scancodeDone, 0);
        check_eq("midrst_err", frameError, 0);
        exp_q.delete();
        last_good = 8'h00;
        ps2Data   = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (TIMEOUT_CYCLES + 50) @(posedge clk);
        send_frame(8'h77, 0, 0, 11, 0);
        wait_drain(200);

        for (int i = 0; i < 24; i++) begin
            d    = 8'($urandom);
            kind = $urandom_range(0, 5);
            send_frame(d, kind == 4, kind == 5, 11, $urandom_range(0, 3) == 0);
            if ($urandom_range(0, 1) == 1) begin
                wait_drain(200);
            end
        end
        wait_drain(300);
        repeat (20) @(posedge clk);
        #1;
        check_eq("final_scancode", scancode, last_good);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
